transport_ctrl: RTL and testbench

Parametrised record/play transport controller for the audio recorder. It sits between the user buttons, the I2S sample clock and the SRAM controller. It runs the INIT/STOP/RUN/PAUSE state machine for both modes and generates the SRAM sample addresses and write/read strobes. Beyond the previous controller it adds multiple recording slots with per-slot length tracking, a parametrised speed range, and internal button edge detection.

---
 rtl/transport_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_transport_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/transport_ctrl.sv
// transport_ctrl: record/play transport state machine for the audio
// recorder, with per-slot lengths, SRAM addressing and a speed ladder.
module transport_ctrl #(
    parameter int ADDR_W = 20,
    parameter int SLOTS = 4,
    parameter int MAX_SPEED = 8,
    localparam int SLOT_W = $clog2(SLOTS),
    localparam int OFF_W = ADDR_W - SLOT_W,
    localparam int SPD_W = $clog2(MAX_SPEED + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              I2C_down,
    input  logic              playRecord,
    input  logic              stop,
    input  logic              fast,
    input  logic              slow,
    input  logic              slotNext,
    input  logic              mode,
    input  logic              sample_tick,
    output logic [2:0]        o_state,
    output logic [ADDR_W-1:0] addr,
    output logic              wr_en,
    output logic              rd_en,
    output logic              speed_fast,
    output logic [SPD_W-1:0]  speed_ratio,
    output logic [SLOT_W-1:0] slot,
    output logic [OFF_W:0]    slot_len,
    output logic              full
);

    localparam logic [2:0] INIT          = 3'b101;
    localparam logic [2:0] PLAY_STOP     = 3'b000;
    localparam logic [2:0] PLAY_PLAY     = 3'b010;
    localparam logic [2:0] PLAY_PAUSE    = 3'b011;
    localparam logic [2:0] RECORD_STOP   = 3'b100;
    localparam logic [2:0] RECORD_RECORD = 3'b110;
    localparam logic [2:0] RECORD_PAUSE  = 3'b111;

    localparam int OW = OFF_W + 1;
    localparam logic [OFF_W:0]    O1   = OW'(1);
    localparam logic [OFF_W-1:0]  LAST = '1;
    localparam logic [SPD_W-1:0]  R1   = SPD_W'(1);
    localparam logic [SPD_W-1:0]  R2   = SPD_W'(2);
    localparam logic [SPD_W-1:0]  RMAX = SPD_W'(MAX_SPEED);
    localparam logic [SLOT_W-1:0] S1   = SLOT_W'(1);

    logic [4:0]        btn_q1, btn_q2, press;
    logic              mode_q;
    logic [2:0]        state, st_n;
    logic [OFF_W:0]    offset, off_n, step;
    logic [SPD_W-1:0]  hold, hold_n;
    logic [OFF_W:0]    lens [SLOTS];
    logic [SLOT_W-1:0] slot_n;
    logic [ADDR_W-1:0] addr_n;
    logic              wr_n, rd_n, full_n, clr_len;
    logic              sf_n, rec_n;
    logic [SPD_W-1:0]  sr_n;
    logic              p_play, p_stop, p_fast, p_slow, p_next, mode_chg;

    assign press    = btn_q1 & ~btn_q2;
    assign p_stop   = press[3];
    assign p_play   = press[4] & ~press[3];
    assign p_fast   = press[2] & ~press[1];
    assign p_slow   = press[1] & ~press[2];
    assign p_next   = press[0];
    assign mode_chg = mode_q != state[2];
    assign slot_len = lens[slot];
    assign o_state  = state;

    // Next transport state, offset, hold counter and access strobes
    always_comb begin
        st_n    = state;
        off_n   = offset;
        hold_n  = hold;
        step    = '0;
        wr_n    = 1'b0;
        rd_n    = 1'b0;
        full_n  = 1'b0;
        slot_n  = slot;
        clr_len = 1'b0;
        case (state)
            INIT: begin
                if (I2C_down) st_n = {mode_q, 2'b00};
            end
            PLAY_STOP, RECORD_STOP: begin
                if (mode_chg) begin
                    st_n = {mode_q, 2'b00};
                end else if (p_play && (state[2] || slot_len != '0)) begin
                    st_n    = {state[2], 2'b10};
                    clr_len = state[2];
                end
                if (p_next) slot_n = slot + S1;
            end
            PLAY_PLAY: begin
                if (sample_tick) begin
                    rd_n = 1'b1;
                    if (speed_fast) begin
                        step = OW'(speed_ratio);
                    end else if (hold >= speed_ratio - R1) begin
                        step   = O1;
                        hold_n = '0;
                    end else begin
                        hold_n = hold + R1;
                    end
                    off_n = offset + step;
                    if (off_n >= slot_len) st_n = PLAY_STOP;
                end
                if (p_stop) st_n = PLAY_STOP;
                else if (p_play && st_n == PLAY_PLAY) st_n = PLAY_PAUSE;
            end
            RECORD_RECORD: begin
                if (sample_tick) begin
                    wr_n  = 1'b1;
                    off_n = offset + O1;
                    if (offset[OFF_W-1:0] == LAST) begin
                        full_n = 1'b1;
                        st_n   = RECORD_STOP;
                    end
                end
                if (p_stop) st_n = RECORD_STOP;
                else if (p_play && st_n == RECORD_RECORD) st_n = RECORD_PAUSE;
            end
            PLAY_PAUSE, RECORD_PAUSE: begin
                if (mode_chg) st_n = {mode_q, 2'b00};
                else if (p_stop) st_n = {state[2], 2'b00};
                else if (p_play) st_n = {state[2], 2'b10};
            end
            default: st_n = INIT;
        endcase
        if (st_n[1:0] == 2'b00) begin
            off_n  = '0;
            hold_n = '0;
        end
        if (wr_n || rd_n) addr_n = {slot, offset[OFF_W-1:0]};
        else addr_n = {slot_n, off_n[OFF_W-1:0]};
    end

    // Speed ladder: 1/MAX .. 1/2, 1x, 2 .. MAX; record forces 1x
    always_comb begin
        sf_n  = speed_fast;
        sr_n  = speed_ratio;
        rec_n = st_n[2] && st_n != INIT;
        if (rec_n) begin
            sf_n = 1'b1;
            sr_n = R1;
        end else if (!state[2]) begin
            if (p_fast) begin
                if (speed_fast) begin
                    if (speed_ratio != RMAX) sr_n = speed_ratio + R1;
                end else if (speed_ratio == R2) begin
                    sf_n = 1'b1;
                    sr_n = R1;
                end else begin
                    sr_n = speed_ratio - R1;
                end
            end else if (p_slow) begin
                if (!speed_fast) begin
                    if (speed_ratio != RMAX) sr_n = speed_ratio + R1;
                end else if (speed_ratio == R1) begin
                    sf_n = 1'b0;
                    sr_n = R2;
                end else begin
                    sr_n = speed_ratio - R1;
                end
            end
        end
    end

    // Control registers and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_q1      <= '0;
            btn_q2      <= '0;
            mode_q      <= 1'b0;
            state       <= INIT;
            offset      <= '0;
            hold        <= '0;
            slot        <= '0;
            addr        <= '0;
            wr_en       <= 1'b0;
            rd_en       <= 1'b0;
            full        <= 1'b0;
            speed_fast  <= 1'b1;
            speed_ratio <= R1;
        end else begin
            btn_q1      <= {playRecord, stop, fast, slow, slotNext};
            btn_q2      <= btn_q1;
            mode_q      <= mode;
            state       <= st_n;
            offset      <= off_n;
            hold        <= hold_n;
            slot        <= slot_n;
            addr        <= addr_n;
            wr_en       <= wr_n;
            rd_en       <= rd_n;
            full        <= full_n;
            speed_fast  <= sf_n;
            speed_ratio <= sr_n;
        end
    end

    // Per-slot recorded length, cleared on a fresh recording
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SLOTS; i++) lens[i] <= '0;
        end else if (clr_len) begin
            lens[slot] <= '0;
        end else if (wr_n) begin
            lens[slot] <= offset + O1;
        end
    end

endmodule

// File: tb/tb_transport_ctrl.sv
// tb_transport_ctrl: directed vectors for transport_ctrl with
// ADDR_W=6, SLOTS=4, MAX_SPEED=3.
module tb_transport_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       I2C_down = 1'b0;
    logic       playRecord = 1'b0;
    logic       stop = 1'b0;
    logic       fast = 1'b0;
    logic       slow = 1'b0;
    logic       slotNext = 1'b0;
    logic       mode = 1'b1;
    logic       sample_tick = 1'b0;
    logic [2:0] o_state;
    logic [5:0] addr;
    logic       wr_en, rd_en, speed_fast, full;
    logic [1:0] speed_ratio, slot;
    logic [4:0] slot_len;

    transport_ctrl #(.ADDR_W(6), .SLOTS(4), .MAX_SPEED(3)) dut (
        .clk(clk), .rst(rst), .I2C_down(I2C_down),
        .playRecord(playRecord), .stop(stop), .fast(fast),
        .slow(slow), .slotNext(slotNext), .mode(mode),
        .sample_tick(sample_tick), .o_state(o_state), .addr(addr),
        .wr_en(wr_en), .rd_en(rd_en), .speed_fast(speed_fast),
        .speed_ratio(speed_ratio), .slot(slot), .slot_len(slot_len),
        .full(full)
    );

    always #5 clk = ~clk;

    localparam int A_IDLE = 0, A_PLAY = 1, A_STOP = 2, A_FAST = 3;
    localparam int A_SLOW = 4, A_NEXT = 5, A_TICK = 6;

    typedef struct {
        int         act;
        logic       m;
        logic [2:0] st;
        logic       wr;
        logic       rd;
        logic [5:0] ad;
        logic [4:0] len;
        logic       sf;
        logic [1:0] sr;
    } vec_t;

    vec_t tv[$];
    int checks = 0;
    int failures = 0;

    function automatic vec_t mk(int a, logic m, logic [2:0] st,
                                logic wr, logic rd, logic [5:0] ad,
                                logic [4:0] len, logic sf, logic [1:0] sr);
        vec_t v;
        v.act = a; v.m = m; v.st = st; v.wr = wr; v.rd = rd;
        v.ad = ad; v.len = len; v.sf = sf; v.sr = sr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic btn(input logic [4:0] v);
        {playRecord, stop, fast, slow, slotNext} = v;
        cyc();
        {playRecord, stop, fast, slow, slotNext} = '0;
        cyc();
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
    endtask

    task automatic do_act(input int a);
        case (a)
            A_PLAY: btn(5'b10000);
            A_STOP: btn(5'b01000);
            A_FAST: btn(5'b00100);
            A_SLOW: btn(5'b00010);
            A_NEXT: btn(5'b00001);
            A_TICK: tick();
            default: begin cyc(); cyc(); end
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // record slot 0 for 3 samples
        tv.push_back(mk(A_PLAY, 1, 3'b110, 0, 0, 6'h00, 0, 1, 1));
        tv.push_back(mk(A_TICK, 1, 3'b110, 1, 0, 6'h00, 1, 1, 1));
        tv.push_back(mk(A_TICK, 1, 3'b110, 1, 0, 6'h01, 2, 1, 1));
        tv.push_back(mk(A_TICK, 1, 3'b110, 1, 0, 6'h02, 3, 1, 1));
        tv.push_back(mk(A_STOP, 1, 3'b100, 0, 0, 6'h00, 3, 1, 1));
        // fast 2x play to end of data
        tv.push_back(mk(A_IDLE, 0, 3'b000, 0, 0, 6'h00, 3, 1, 1));
        tv.push_back(mk(A_FAST, 0, 3'b000, 0, 0, 6'h00, 3, 1, 2));
        tv.push_back(mk(A_PLAY, 0, 3'b010, 0, 0, 6'h00, 3, 1, 2));
        tv.push_back(mk(A_TICK, 0, 3'b010, 0, 1, 6'h00, 3, 1, 2));
        tv.push_back(mk(A_TICK, 0, 3'b000, 0, 1, 6'h02, 3, 1, 2));
        tv.push_back(mk(A_IDLE, 0, 3'b000, 0, 0, 6'h00, 3, 1, 2));
        // slow ladder saturating at 1/3
        tv.push_back(mk(A_SLOW, 0, 3'b000, 0, 0, 6'h00, 3, 1, 1));
        tv.push_back(mk(A_SLOW, 0, 3'b000, 0, 0, 6'h00, 3, 0, 2));
        tv.push_back(mk(A_SLOW, 0, 3'b000, 0, 0, 6'h00, 3, 0, 3));
        tv.push_back(mk(A_SLOW, 0, 3'b000, 0, 0, 6'h00, 3, 0, 3));
        tv.push_back(mk(A_SLOW, 0, 3'b000, 0, 0, 6'h00, 3, 0, 3));
        // slow play with pause after the fourth tick
        tv.push_back(mk(A_PLAY, 0, 3'b010, 0, 0, 6'h00, 3, 0, 3));
        tv.push_back(mk(A_TICK, 0, 3'b010, 0, 1, 6'h00, 3, 0, 3));
        tv.push_back(mk(A_TICK, 0, 3'b010, 0, 1, 6'h00, 3, 0, 3));
        tv.push_back(mk(A_TICK, 0, 3'b010, 0, 1, 6'h00, 3, 0, 3));
        tv.push_back(mk(A_TICK, 0, 3'b010, 0, 1, 6'h01, 3, 0, 3));
        tv.push_back(mk(A_PLAY, 0, 3'b011, 0, 0, 6'h01, 3, 0, 3));
        tv.push_back(mk(A_TICK, 0, 3'b011, 0, 0, 6'h01, 3, 0, 3));
        tv.push_back(mk(A_PLAY, 0, 3'b010, 0, 0, 6'h01, 3, 0, 3));
        tv.push_back(mk(A_TICK, 0, 3'b010, 0, 1, 6'h01, 3, 0, 3));
        tv.push_back(mk(A_TICK, 0, 3'b010, 0, 1, 6'h01, 3, 0, 3));
        tv.push_back(mk(A_TICK, 0, 3'b010, 0, 1, 6'h02, 3, 0, 3));
        tv.push_back(mk(A_TICK, 0, 3'b010, 0, 1, 6'h02, 3, 0, 3));
        tv.push_back(mk(A_TICK, 0, 3'b000, 0, 1, 6'h02, 3, 0, 3));
        tv.push_back(mk(A_IDLE, 0, 3'b000, 0, 0, 6'h00, 3, 0, 3));
        // empty slot ignores play; move to slot 2 and arm record
        tv.push_back(mk(A_NEXT, 0, 3'b000, 0, 0, 6'h10, 0, 0, 3));
        tv.push_back(mk(A_PLAY, 0, 3'b000, 0, 0, 6'h10, 0, 0, 3));
        tv.push_back(mk(A_NEXT, 0, 3'b000, 0, 0, 6'h20, 0, 0, 3));
        tv.push_back(mk(A_IDLE, 1, 3'b100, 0, 0, 6'h20, 0, 1, 1));
        tv.push_back(mk(A_PLAY, 1, 3'b110, 0, 0, 6'h20, 0, 1, 1));

        // reset state
        repeat (3) cyc();
        chk("rst_state", o_state, 3'b101);
        chk("rst_addr", addr, 6'h00);
        chk("rst_wr", wr_en, 1'b0);
        chk("rst_rd", rd_en, 1'b0);
        chk("rst_sf", speed_fast, 1'b1);
        chk("rst_sr", speed_ratio, 2'd1);
        chk("rst_slot", slot, 2'd0);
        chk("rst_len", slot_len, 5'd0);
        chk("rst_full", full, 1'b0);
        rst = 1'b1;

        // init gating
        repeat (20) cyc();
        chk("init_wait", o_state, 3'b101);
        I2C_down = 1'b1;
        cyc();
        chk("init_done", o_state, 3'b100);

        foreach (tv[i]) begin
            mode = tv[i].m;
            do_act(tv[i].act);
            chk($sformatf("v%0d_state", i), o_state, tv[i].st);
            chk($sformatf("v%0d_wr", i), wr_en, tv[i].wr);
            chk($sformatf("v%0d_rd", i), rd_en, tv[i].rd);
            chk($sformatf("v%0d_addr", i), addr, tv[i].ad);
            chk($sformatf("v%0d_len", i), slot_len, tv[i].len);
            chk($sformatf("v%0d_sf", i), speed_fast, tv[i].sf);
            chk($sformatf("v%0d_sr", i), speed_ratio, tv[i].sr);
            chk($sformatf("v%0d_full", i), full, 1'b0);
        end

        // fill slot 2 with 16 samples
        for (int i = 0; i < 16; i++) begin
            tick();
            chk($sformatf("fill%0d_wr", i), wr_en, 1'b1);
            chk($sformatf("fill%0d_addr", i), addr, 6'h20 + i);
            chk($sformatf("fill%0d_full", i), full, i == 15);
            chk($sformatf("fill%0d_state", i), o_state,
                (i == 15) ? 3'b100 : 3'b110);
            chk($sformatf("fill%0d_len", i), slot_len, i + 1);
        end
        cyc();
        chk("fill_full_off", full, 1'b0);
        chk("fill_len_hold", slot_len, 5'd16);
        chk("fill_wr_off", wr_en, 1'b0);

        // mode ignored while recording; stop wins over playRecord
        btn(5'b10000);
        chk("rec2_state", o_state, 3'b110);
        mode = 1'b0;
        repeat (3) cyc();
        chk("run_mode_ign", o_state, 3'b110);
        mode = 1'b1;
        cyc();
        cyc();
        btn(5'b11000);
        chk("stop_prio", o_state, 3'b100);

        // held fast button steps only once
        mode = 1'b0;
        cyc();
        cyc();
        chk("hold_state", o_state, 3'b000);
        fast = 1'b1;
        repeat (5) cyc();
        fast = 1'b0;
        cyc();
        chk("hold_sf", speed_fast, 1'b1);
        chk("hold_sr", speed_ratio, 2'd2);

        // asynchronous reset mid-operation
        rst = 1'b0;
        #2;
        chk("arst_state", o_state, 3'b101);
        chk("arst_slot", slot, 2'd0);
        chk("arst_sr", speed_ratio, 2'd1);
        chk("arst_len", slot_len, 5'd0);
        chk("arst_addr", addr, 6'h00);
        cyc();
        rst = 1'b1;
        cyc();
        chk("arst_len2", slot_len, 5'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
